// File: rtl/coeff_reconstruct.sv
// coeff_reconstruct: final CAVLC stage. Buffers decoded levels, places each one at
// its zig-zag position using run_before values, then streams the whole block.
module coeff_reconstruct #(
    parameter int LEVEL_W   = 13,
    parameter int MAX_COEFF = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [4:0]                TotalCoeff,
    input  logic [3:0]                TotalZeros,
    input  logic signed [LEVEL_W-1:0] LevelIn,
    input  logic                      LevelWr,
    input  logic [3:0]                RunIn,
    input  logic                      RunValid,
    output logic                      RunReady,
    output logic signed [LEVEL_W-1:0] CoeffOut,
    output logic [3:0]                CoeffIdx,
    output logic                      CoeffValid,
    input  logic                      CoeffReady,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Error
);

    typedef enum logic [1:0] {IDLE, LEVELS, PLACE, EMIT} stateT;

    localparam logic [4:0] MaxCoeff = 5'(MAX_COEFF);
    localparam logic [3:0] LastIdx  = 4'(MAX_COEFF - 1);

    stateT state;
    logic [4:0] tc;
    logic [4:0] zl;
    logic [3:0] pos;
    logic [3:0] k;
    logic [3:0] wcnt;
    logic [3:0] emitIdx;
    logic       doneReg;
    logic       errReg;
    logic signed [LEVEL_W-1:0] levelBuf [MAX_COEFF];
    logic signed [LEVEL_W-1:0] coef     [MAX_COEFF];

    logic [4:0] tcClamp;
    logic [4:0] zlLimit;
    logic [4:0] zlClamp;
    logic       startErr;
    logic [3:0] posInit;
    logic [3:0] tcLast;
    logic       runErr;
    logic [4:0] runClamp;

    // Oversized blocks are clamped so Pos always lands inside the coefficient array.
    always_comb begin
        tcClamp  = (TotalCoeff > MaxCoeff) ? MaxCoeff : TotalCoeff;
        zlLimit  = MaxCoeff - tcClamp;
        zlClamp  = ({1'b0, TotalZeros} > zlLimit) ? zlLimit : {1'b0, TotalZeros};
        startErr = (TotalCoeff > MaxCoeff) ||
                   (({1'b0, TotalCoeff} + {2'b0, TotalZeros}) > {1'b0, MaxCoeff});
        posInit  = 4'(tcClamp + zlClamp - 5'd1);
        tcLast   = 4'(tc - 5'd1);
        runErr   = {1'b0, RunIn} > zl;
        runClamp = runErr ? zl : {1'b0, RunIn};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            tc      <= '0;
            zl      <= '0;
            pos     <= '0;
            k       <= '0;
            wcnt    <= '0;
            emitIdx <= '0;
            doneReg <= 1'b0;
            errReg  <= 1'b0;
            for (int i = 0; i < MAX_COEFF; i++) begin
                levelBuf[i] <= '0;
                coef[i]     <= '0;
            end
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        tc      <= tcClamp;
                        zl      <= zlClamp;
                        pos     <= posInit;
                        k       <= '0;
                        wcnt    <= '0;
                        emitIdx <= '0;
                        errReg  <= startErr;
                        for (int i = 0; i < MAX_COEFF; i++) begin
                            coef[i] <= '0;
                        end
                        state <= (tcClamp == 5'd0) ? EMIT : LEVELS;
                    end
                end
                LEVELS: begin
                    if (LevelWr) begin
                        levelBuf[wcnt] <= LevelIn;
                        wcnt           <= wcnt + 4'd1;
                        if (wcnt == tcLast) begin
                            state <= PLACE;
                        end
                    end
                end
                PLACE: begin
                    // The final level needs no run; with no zeros left every run is 0.
                    if (k == tcLast) begin
                        coef[pos] <= levelBuf[k];
                        state     <= EMIT;
                    end else if (zl == 5'd0) begin
                        coef[pos] <= levelBuf[k];
                        pos       <= pos - 4'd1;
                        k         <= k + 4'd1;
                    end else if (RunValid) begin
                        coef[pos] <= levelBuf[k];
                        pos       <= 4'({1'b0, pos} - runClamp - 5'd1);
                        zl        <= zl - runClamp;
                        k         <= k + 4'd1;
                        if (runErr) begin
                            errReg <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (CoeffReady) begin
                        if (emitIdx == LastIdx) begin
                            state   <= IDLE;
                            doneReg <= 1'b1;
                        end else begin
                            emitIdx <= emitIdx + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign RunReady   = (state == PLACE) && (k != tcLast) && (zl != 5'd0);
    assign CoeffValid = (state == EMIT);
    assign CoeffIdx   = CoeffValid ? emitIdx : 4'd0;
    assign CoeffOut   = CoeffValid ? coef[emitIdx] : '0;
    assign Busy       = (state != IDLE);
    assign Done       = doneReg;
    assign Error      = errReg;

endmodule

// File: tb/tb_coeff_reconstruct.sv
// tb_coeff_reconstruct: directed and randomized blocks checked against a
// behavioural CAVLC coefficient-placement model.
module tb_coeff_reconstruct;

    logic              Clk;
    logic              Reset;
    logic              Start;
    logic [4:0]        TotalCoeff;
    logic [3:0]        TotalZeros;
    logic signed [12:0] LevelIn;
    logic              LevelWr;
    logic [3:0]        RunIn;
    logic              RunValid;
    logic              RunReady;
    logic signed [12:0] CoeffOut;
    logic [3:0]        CoeffIdx;
    logic              CoeffValid;
    logic              CoeffReady;
    logic              Busy;
    logic              Done;
    logic              Error;

    coeff_reconstruct #(.LEVEL_W(13), .MAX_COEFF(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .TotalCoeff(TotalCoeff), .TotalZeros(TotalZeros),
        .LevelIn(LevelIn), .LevelWr(LevelWr),
        .RunIn(RunIn), .RunValid(RunValid), .RunReady(RunReady),
        .CoeffOut(CoeffOut), .CoeffIdx(CoeffIdx), .CoeffValid(CoeffValid),
        .CoeffReady(CoeffReady), .Busy(Busy), .Done(Done), .Error(Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    logic signed [12:0] stimLevels [16];
    logic [3:0]         stimRuns   [16];
    logic signed [12:0] expCoef    [16];
    logic signed [12:0] got        [16];
    bit                 expErr;
    int                 expRuns;
    int                 handshakes;
    int                 rrCycles;
    int                 firstValid;
    int                 runIdx;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: walk levels high-frequency first, each one sitting run_before
    // zeros above the next, starting at the last nonzero position.
    task automatic computeExpected(input int tc, input int tz);
        int tcC, zl, pos, r;
        tcC    = (tc > 16) ? 16 : tc;
        expErr = (tc > 16) || (tc + tz > 16);
        zl     = (tz > 16 - tcC) ? 16 - tcC : tz;
        for (int i = 0; i < 16; i++) expCoef[i] = '0;
        pos     = tcC + zl - 1;
        expRuns = 0;
        for (int lv = 0; lv < tcC; lv++) begin
            expCoef[pos] = stimLevels[lv];
            if (lv == tcC - 1) break;
            r = 0;
            if (zl > 0) begin
                r = int'(stimRuns[expRuns]);
                expRuns++;
                if (r > zl) begin
                    expErr = 1'b1;
                    r      = zl;
                end
            end
            pos = pos - (r + 1);
            zl  = zl - r;
        end
    endtask

    task automatic startBlock(input int tc, input int tz);
        TotalCoeff = 5'(tc);
        TotalZeros = 4'(tz);
        Start      = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        checkOutput("busy_after_start", Busy, 1);
    endtask

    task automatic writeLevels(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    LevelWr = 1'b0;
                    @(posedge Clk); #1;
                end
            end
            LevelIn = stimLevels[i];
            LevelWr = 1'b1;
            @(posedge Clk); #1;
        end
        LevelWr = 1'b0;
    endtask

    // readyMode: 0 always ready, 1 random ready, 2 hold ready low 3 cycles at idx 7.
    task automatic runToDone(input int readyMode, input int budget);
        int nextIdx  = 0;
        int stall    = 0;
        int cyc      = 0;
        bit finished = 0;
        handshakes = 0;
        rrCycles   = 0;
        firstValid = -1;
        runIdx     = 0;
        for (int i = 0; i < 16; i++) got[i] = 'x;
        while (!finished && cyc < budget) begin
            if (runIdx < 16 && $urandom_range(0, 3) != 0) begin
                RunValid = 1'b1;
                RunIn    = stimRuns[runIdx];
            end else begin
                RunValid = 1'b0;
                RunIn    = 4'($urandom_range(0, 15));
            end
            LevelWr = 1'($urandom_range(0, 1));
            LevelIn = 13'($urandom_range(0, 8191));
            case (readyMode)
                0: CoeffReady = 1'b1;
                1: CoeffReady = ($urandom_range(0, 2) != 0);
                default: begin
                    if (CoeffValid && CoeffIdx == 4'd7 && stall < 3) begin
                        CoeffReady = 1'b0;
                        stall++;
                        checkOutput("stall_idx", CoeffIdx, 7);
                        checkOutput("stall_out", CoeffOut, expCoef[7]);
                    end else begin
                        CoeffReady = 1'b1;
                    end
                end
            endcase
            if (RunReady) rrCycles++;
            if (RunReady && RunValid) begin
                handshakes++;
                runIdx++;
            end
            if (CoeffValid && firstValid < 0) firstValid = cyc;
            if (CoeffValid && CoeffReady) begin
                checkOutput("emit_idx", CoeffIdx, nextIdx);
                got[CoeffIdx] = CoeffOut;
                nextIdx++;
            end
            @(posedge Clk); #1;
            cyc++;
            if (nextIdx == 16) finished = 1'b1;
        end
        LevelWr    = 1'b0;
        RunValid   = 1'b0;
        CoeffReady = 1'b0;
        checkOutput("emitted_count", nextIdx, 16);
        if (finished) begin
            checkOutput("done_pulse", Done, 1);
            checkOutput("busy_after_done", Busy, 0);
            @(posedge Clk); #1;
            checkOutput("done_width", Done, 0);
        end
    endtask

    task automatic applyStimulus(input int tc, input int tz, input int readyMode, input bit gaps);
        computeExpected(tc, tz);
        startBlock(tc, tz);
        writeLevels((tc > 16) ? 16 : tc, gaps);
        runToDone(readyMode, 600);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("coef%0d", i), got[i], expCoef[i]);
        checkOutput("error_flag", Error, expErr);
        checkOutput("run_handshakes", handshakes, expRuns);
        if (expRuns == 0) checkOutput("runready_cycles", rrCycles, 0);
    endtask

    initial begin
        int tc, tz;
        Reset = 1'b1; Start = 1'b0; TotalCoeff = '0; TotalZeros = '0;
        LevelIn = '0; LevelWr = 1'b0; RunIn = '0; RunValid = 1'b0; CoeffReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("reset_busy", Busy, 0);
        checkOutput("reset_valid", CoeffValid, 0);
        checkOutput("reset_done", Done, 0);
        checkOutput("reset_error", Error, 0);
        checkOutput("reset_runready", RunReady, 0);
        checkOutput("reset_coeffout", CoeffOut, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // TC=3 TZ=2, levels 5,-2,7, runs 1 then 0.
        stimLevels[0] = 13'sd5; stimLevels[1] = -13'sd2; stimLevels[2] = 13'sd7;
        for (int i = 0; i < 16; i++) stimRuns[i] = 4'd0;
        stimRuns[0] = 4'd1;
        applyStimulus(3, 2, 0, 0);
        checkOutput("d1_idx0", got[0], 0);
        checkOutput("d1_idx1", got[1], 7);
        checkOutput("d1_idx2", got[2], -2);
        checkOutput("d1_idx4", got[4], 5);

        // TC=0: all zeros, valid one cycle after Start.
        applyStimulus(0, 0, 0, 0);
        checkOutput("tc0_first_valid", firstValid, 0);
        checkOutput("tc0_runready", rrCycles, 0);

        // TC=16 TZ=0: levels 1..16 land in reverse order.
        for (int i = 0; i < 16; i++) stimLevels[i] = 13'(i + 1);
        applyStimulus(16, 0, 0, 0);
        checkOutput("tc16_idx0", got[0], 16);
        checkOutput("tc16_idx15", got[15], 1);
        checkOutput("tc16_first_valid", firstValid, 16);
        checkOutput("tc16_handshakes", handshakes, 0);

        // Oversized run is clamped and flags Error.
        stimLevels[0] = 13'sd11; stimLevels[1] = -13'sd4;
        stimRuns[0] = 4'd5;
        applyStimulus(2, 3, 0, 0);
        checkOutput("clamp_error", Error, 1);
        checkOutput("clamp_idx0", got[0], -4);
        checkOutput("clamp_idx4", got[4], 11);

        // Start clears the sticky Error; consumer stalls at idx 7.
        for (int i = 0; i < 16; i++) stimLevels[i] = 13'(100 + 3 * i);
        for (int i = 0; i < 16; i++) stimRuns[i] = 4'd0;
        applyStimulus(10, 3, 2, 1);
        checkOutput("error_cleared", Error, 0);

        // Oversized TotalCoeff.
        for (int i = 0; i < 16; i++) stimLevels[i] = 13'(i * 7 - 40);
        applyStimulus(20, 2, 1, 0);

        // Reset while stalled in PLACE waiting for a run.
        stimLevels[0] = 13'sd5; stimLevels[1] = -13'sd2; stimLevels[2] = 13'sd7;
        startBlock(3, 2);
        writeLevels(3, 0);
        checkOutput("place_runready", RunReady, 1);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        checkOutput("midreset_busy", Busy, 0);
        checkOutput("midreset_valid", CoeffValid, 0);
        checkOutput("midreset_runready", RunReady, 0);
        stimLevels[0] = -13'sd9;
        applyStimulus(1, 0, 0, 0);
        checkOutput("after_reset_idx0", got[0], -9);
        checkOutput("after_reset_idx1", got[1], 0);
        checkOutput("tc1_first_valid", firstValid, 1);

        // Randomized blocks.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                tc = $urandom_range(0, 20);
                tz = $urandom_range(0, 15);
            end else begin
                tc = $urandom_range(0, 16);
                tz = $urandom_range(0, (16 - tc > 15) ? 15 : 16 - tc);
            end
            for (int i = 0; i < 16; i++) begin
                stimLevels[i] = 13'($urandom_range(0, 8191));
                stimRuns[i]   = 4'($urandom_range(0, 3));
            end
            applyStimulus(tc, tz, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
